// File: rtl/spi_txn_arbiter_if.sv
// Bundle between the requesters, the SPI master and the arbiter.
// Clock and reset stay outside as plain ports.
interface spi_txn_arbiter_if;
  logic [1:0] req;
  logic [7:0] tx_data0;
  logic [7:0] tx_data1;
  logic [7:0] data_out_master;
  logic       load_master;
  logic       start;
  logic       read_master;
  logic [7:0] data_in_master;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [7:0] rx_data;
  logic       busy;

  modport slave (
    input  req,
    input  tx_data0,
    input  tx_data1,
    input  data_out_master,
    output load_master,
    output start,
    output read_master,
    output data_in_master,
    output gnt,
    output done,
    output rx_data,
    output busy
  );

  modport master (
    output req,
    output tx_data0,
    output tx_data1,
    output data_out_master,
    input  load_master,
    input  start,
    input  read_master,
    input  data_in_master,
    input  gnt,
    input  done,
    input  rx_data,
    input  busy
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sequencing two requesters onto one SPI master.
// All outputs are registered from the next-state decode.
module spi_txn_arbiter #(
  parameter int SHIFT_CYCLES = 16
) (
  input logic              mclk,
  input logic              reset,
  spi_txn_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    SHIFT,
    READ,
    DONE
  } state_t;

  localparam int CW = (SHIFT_CYCLES > 1) ?
                      $clog2(SHIFT_CYCLES) : 1;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last, last_n;
  logic          win;
  logic [1:0]    gnt_q, gnt_n;
  logic [1:0]    done_q, done_n;
  logic [7:0]    din_q, din_n;
  logic [7:0]    rx_q, rx_n;
  logic          ld_q, st_q, rd_q, busy_q;

  // last holds the index of the previous winner
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (bus.req == 2'b11): win = ~last;
      (bus.req == 2'b10): win = 1'b1;
      default:            win = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    gnt_n   = gnt_q;
    din_n   = din_q;
    rx_n    = rx_q;
    done_n  = 2'b00;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          state_n = LOAD;
          last_n  = win;
          gnt_n   = win ? 2'b10 : 2'b01;
          din_n   = win ? bus.tx_data1
                        : bus.tx_data0;
        end
      end
      LOAD: state_n = START;
      START: begin
        state_n = SHIFT;
        cnt_n   = CW'(SHIFT_CYCLES - 1);
      end
      SHIFT: begin
        if (cnt == '0) state_n = READ;
        else           cnt_n   = cnt - 1'b1;
      end
      READ: begin
        state_n = DONE;
        rx_n    = bus.data_out_master;
        done_n  = gnt_q;
      end
      DONE: begin
        state_n = IDLE;
        gnt_n   = 2'b00;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= 1'b1;
      gnt_q  <= 2'b00;
      done_q <= 2'b00;
      din_q  <= 8'h00;
      rx_q   <= 8'h00;
      ld_q   <= 1'b0;
      st_q   <= 1'b0;
      rd_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      last   <= last_n;
      gnt_q  <= gnt_n;
      done_q <= done_n;
      din_q  <= din_n;
      rx_q   <= rx_n;
      ld_q   <= (state_n == LOAD);
      st_q   <= (state_n == START);
      rd_q   <= (state_n == READ);
      busy_q <= (state_n != IDLE);
    end
  end

  assign bus.load_master    = ld_q;
  assign bus.start          = st_q;
  assign bus.read_master    = rd_q;
  assign bus.data_in_master = din_q;
  assign bus.gnt            = gnt_q;
  assign bus.done           = done_q;
  assign bus.rx_data        = rx_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed and random bench for spi_txn_arbiter.
// A timeline model predicts every cycle; a queue holds grant results.
module tb_spi_txn_arbiter;

  localparam int N = 16;

  logic mclk;
  logic reset;

  spi_txn_arbiter_if bus ();
  spi_txn_arbiter_if bus1 ();

  spi_txn_arbiter #(.SHIFT_CYCLES(N)) u_dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus)
  );

  spi_txn_arbiter #(.SHIFT_CYCLES(1)) u_dut1 (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus1)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int n_assert = 0;
  int n_fail   = 0;

  int         m_t;
  logic       m_last;
  logic [1:0] m_gnt;
  logic [7:0] m_din;
  logic [7:0] m_rx;
  logic [9:0] sb[$];

  logic [1:0] expg [3] = '{2'b01, 2'b10, 2'b01};
  logic [4:0] exp1 [6] = '{5'b10001, 5'b01001, 5'b00001,
                           5'b00101, 5'b00011, 5'b00000};

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t    = 0;
    m_last = 1'b1;
    m_gnt  = 2'b00;
    m_din  = 8'h00;
    m_rx   = 8'h00;
    sb.delete();
  endtask

  task automatic model_step();
    logic w;
    if (!reset) begin
      model_reset();
    end else if (m_t == 0) begin
      if (bus.req != 2'b00) begin
        w      = (bus.req == 2'b11) ? ~m_last : bus.req[1];
        m_last = w;
        m_gnt  = w ? 2'b10 : 2'b01;
        m_din  = w ? bus.tx_data1 : bus.tx_data0;
        m_t    = 1;
        sb.push_back({m_gnt, m_din});
      end
    end else begin
      if (m_t == N + 3) m_rx = bus.data_out_master;
      m_t = (m_t == N + 4) ? 0 : m_t + 1;
    end
  endtask

  task automatic check_cycle();
    logic [7:0] e;
    logic [9:0] s;
    e = {m_t == 1, m_t == 2, m_t == N + 3, m_t != 0,
         (m_t != 0) ? m_gnt : 2'b00,
         (m_t == N + 4) ? m_gnt : 2'b00};
    chk("ctrl", {bus.load_master, bus.start,
                 bus.read_master, bus.busy,
                 bus.gnt, bus.done}, e);
    chk("data_in", bus.data_in_master, m_din);
    chk("rx_data", bus.rx_data, m_rx);
    if (bus.done !== 2'b00) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        s = sb.pop_front();
        chk("sb_done", {bus.done, bus.data_in_master}, s);
      end
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    model_step();
    #1;
    check_cycle();
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    #1;
    model_reset();
    check_cycle();
    chk("rst_busy1", bus1.busy, 1'b0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    bus.req = 2'b00;
    bus.tx_data0 = 8'h00;
    bus.tx_data1 = 8'h00;
    bus.data_out_master = 8'h00;
    bus1.req = 2'b00;
    bus1.tx_data0 = 8'h00;
    bus1.tx_data1 = 8'h00;
    bus1.data_out_master = 8'h00;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    tick();

    // single transaction, full latency
    bus.req = 2'b01;
    bus.tx_data0 = 8'hA5;
    bus.data_out_master = 8'h3C;
    tick();
    chk("t1_load", bus.load_master, 1'b1);
    chk("t1_din", bus.data_in_master, 8'hA5);
    bus.req = 2'b00;
    tick();
    chk("t1_start", bus.start, 1'b1);
    repeat (16) tick();
    tick();
    chk("t1_read", bus.read_master, 1'b1);
    tick();
    chk("t1_done", bus.done, 2'b01);
    chk("t1_rx", bus.rx_data, 8'h3C);
    tick();

    // round robin with both requesting
    reset_dut();
    bus.req = 2'b11;
    bus.tx_data0 = 8'h10;
    bus.tx_data1 = 8'h20;
    bus.data_out_master = 8'h44;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rr_gnt", bus.gnt, expg[k]);
      if (k < 2) repeat (N + 5) tick();
    end
    bus.req = 2'b00;
    repeat (N + 5) tick();

    // requester 1, req dropped, tx changed mid-shift
    bus.req = 2'b10;
    bus.tx_data1 = 8'h77;
    bus.data_out_master = 8'h5E;
    tick();
    bus.req = 2'b00;
    repeat (4) tick();
    bus.tx_data1 = 8'hEE;
    repeat (15) tick();
    chk("t4_done", bus.done, 2'b10);
    chk("t4_din", bus.data_in_master, 8'h77);
    chk("t4_rx", bus.rx_data, 8'h5E);
    tick();

    // reset during shift aborts
    bus.req = 2'b01;
    bus.tx_data0 = 8'h11;
    repeat (5) tick();
    chk("t5_busy", bus.busy, 1'b1);
    reset_dut();
    chk("t5_gnt0", bus.gnt, 2'b00);
    tick();
    chk("t5_regrant", bus.load_master, 1'b1);
    bus.req = 2'b00;
    repeat (N + 6) tick();

    // one shift cycle variant
    bus1.req = 2'b01;
    bus1.tx_data0 = 8'h5A;
    bus1.data_out_master = 8'hC3;
    for (int c = 0; c < 6; c++) begin
      tick();
      bus1.req = 2'b00;
      chk("n1_seq", {bus1.load_master, bus1.start,
                     bus1.read_master, bus1.done[0],
                     bus1.busy}, exp1[c]);
      if (c == 4) chk("n1_rx", bus1.rx_data, 8'hC3);
    end

    // random traffic
    for (int i = 0; i < 1000; i++) begin
      bus.req = 2'($urandom_range(0, 3));
      bus.tx_data0 = 8'($urandom);
      bus.tx_data1 = 8'($urandom);
      bus.data_out_master = 8'($urandom);
      tick();
    end
    bus.req = 2'b00;
    repeat (N + 6) tick();
    chk("sb_drain", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
